uart_sync_fifo: RTL and testbench

Parametrised single-clock FIFO, successor to the UART byte buffer, used for both the UART TX and RX paths.
- Circular buffer with independent read/write pointers, first-word-fall-through output, and a fill-level count.
- Programmable almost-full/almost-empty thresholds for flow control.
- Sticky overflow/underflow error flags for the controller status register.
- All logic, including read, runs on clk; no secondary clock domains.

---
 rtl/uart_sync_fifo.sv | 106 ++++++++++
 tb/tb_uart_sync_fifo.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock circular FIFO shared by the UART TX and RX paths.
// Head word is presented first-word-fall-through. The block also provides a
// fill level, almost-full/almost-empty thresholds and sticky overflow/underflow
// flags.
// Optional build macro UART_FIFO_PEAK_EN enables the high-water-mark register
// on 'peak'. When the macro is not defined, 'peak' is tied to zero.
module uart_sync_fifo #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int AF_LVL = (1 << AW) - 2,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] idata,
  input  logic          rd_en,
  output logic [DW-1:0] odata,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err,
  output logic [AW:0]   peak
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LVL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   lvl_q, lvl_nxt;
  logic          wr_acc, rd_acc;
  logic          ovf_set, udf_set;

  // Status flags are decoded from the registered level only.
  assign level        = lvl_q;
  assign full         = (lvl_q == DEPTH_L);
  assign empty        = (lvl_q == '0);
  assign almost_full  = (lvl_q >= AF_L);
  assign almost_empty = (lvl_q <= AE_L);

  // The head word falls through, and the output is forced to zero while the FIFO is empty so stale memory never leaks out.
  assign odata = empty ? '0 : mem[rd_ptr];

  // Accept decisions use the state before the edge. A write to a full FIFO is accepted when a pop frees a slot in the same cycle.
  always_comb begin
    wr_acc  = wr_en & (~full | rd_en);
    rd_acc  = rd_en & ~empty;
    ovf_set = wr_en & full & ~rd_en;
    udf_set = rd_en & empty;
    lvl_nxt = lvl_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end

  // Storage has no reset. Contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= idata;
  end

  // The pointers wrap naturally at DEPTH. The level tracks accepted pushes minus accepted pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      lvl_q <= lvl_nxt;
    end
  end

  // The error flags are sticky. A set in the same cycle as clr_err takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

`ifdef UART_FIFO_PEAK_EN
  logic [AW:0] peak_q;

  // This register holds the high-water mark of the post-edge level. clr_err restarts tracking from the current level.
  always_ff @(posedge clk) begin
    if (rst)                    peak_q <= '0;
    else if (clr_err)           peak_q <= lvl_nxt;
    else if (lvl_nxt > peak_q)  peak_q <= lvl_nxt;
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// tb_uart_sync_fifo: directed test-plan steps followed by random traffic. The
// DUT is compared against a queue-based reference model.
module tb_uart_sync_fifo;
  localparam int DW = 8, AW = 2, DEPTH = 4, AF = 3, AE = 1;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, clr_err;
  logic [DW-1:0] idata, odata;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   level, peak;

  uart_sync_fifo #(.DW(DW), .AW(AW), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .idata(idata), .rd_en(rd_en),
    .odata(odata), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err), .peak(peak)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model state: the stored words plus the flags, kept at word level.
  logic [DW-1:0] q[$];
  bit m_ovf, m_udf;
  int m_peak;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    int exp_pk;
    n = q.size();
`ifdef UART_FIFO_PEAK_EN
    exp_pk = m_peak;
`else
    exp_pk = 0;
`endif
    check({tag, ".level"}, 32'(level), 32'(n));
    check({tag, ".odata"}, 32'(odata), (n == 0) ? 32'd0 : 32'(q[0]));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"},  32'(full),  32'(n == DEPTH));
    check({tag, ".afull"}, 32'(almost_full),  32'(n >= AF));
    check({tag, ".aempty"},32'(almost_empty), 32'(n <= AE));
    check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    check({tag, ".udf"},   32'(underflow), 32'(m_udf));
    check({tag, ".peak"},  32'(peak), 32'(exp_pk));
  endtask

  // This task drives one cycle of stimulus, advances the model using the state before the edge, and then checks the DUT.
  task automatic step(input string tag, input bit w, input logic [DW-1:0] d,
                      input bit r, input bit c, input bit rs = 1'b0);
    bit was_full, was_empty;
    wr_en = w; idata = d; rd_en = r; clr_err = c; rst = rs;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (rs) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_peak = 0;
    end else begin
      if (r && !was_empty) void'(q.pop_front());
      if (w && (!was_full || r)) q.push_back(d);
      if (w && was_full && !r) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (r && was_empty) m_udf = 1;
      else if (c) m_udf = 0;
      if (c) m_peak = q.size();
      else if (q.size() > m_peak) m_peak = q.size();
    end
    #1;
    check_all(tag);
    wr_en = 0; rd_en = 0; clr_err = 0; rst = 0;
  endtask

  initial begin
    rst = 1; wr_en = 0; rd_en = 0; clr_err = 0; idata = '0;
    m_ovf = 0; m_udf = 0; m_peak = 0;
    step("reset", 0, 0, 0, 0, 1);
    check("reset.odata_zero", 32'(odata), 32'd0);

    step("wr_a1", 1, 8'hA1, 0, 0);
    check("wr_a1.literal", 32'(odata), 32'hA1);
    step("rd_a1", 0, 0, 1, 0);

    // Fill the FIFO to full, then attempt an overflowing write.
    for (int i = 1; i <= 4; i++) step("fill", 1, 8'(i * 8'h11), 0, 0);
    check("fill.full_literal", 32'(full), 32'd1);
    step("ovf_55", 1, 8'h55, 0, 0);
    check("ovf.literal", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) step("drain_ovf", 0, 0, 1, 0);
    step("clr_ovf", 0, 0, 0, 1);

    // A write while full is accepted when a read happens in the same cycle.
    for (int i = 1; i <= 4; i++) step("refill", 1, 8'(i * 8'h11), 0, 0);
    step("full_wr_rd", 1, 8'h66, 1, 0);
    for (int i = 0; i < 4; i++) step("drain_66", 0, 0, 1, 0);
    check("drain_66.literal", 32'(empty), 32'd1);

    // A read while empty is rejected, but a write in the same cycle is still accepted.
    step("empty_rd_wr", 1, 8'h77, 1, 0);
    check("empty_rd_wr.literal", 32'(odata), 32'h77);
    step("clr_udf", 0, 0, 0, 1);
    step("drain_77", 0, 0, 1, 0);

    // Stream words through the FIFO so the pointers wrap several times.
    step("stream0", 1, 8'h00, 0, 0);
    for (int i = 1; i < 10; i++) step("stream", 1, 8'(i), 1, 0);
    step("stream_end", 0, 0, 1, 0);

    // Issue a reset while three words are stored.
    for (int i = 0; i < 3; i++) step("pre_rst", 1, 8'(8'hC0 + i), 0, 0);
    step("mid_rst", 0, 0, 0, 0, 1);

    // Random traffic with occasional clr_err and reset.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
